pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush controller for the 5-stage pipeline. Detects load-use hazards (ID vs. ID/EX load),

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 57 +++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 20 ++
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush controller: FSM states,
// the bundle of pipeline control strobes and its canned per-situation values.
package pipeline_hazard_ctrl_pkg;

    // Controller FSM: normal issue, or EX held by a multi-cycle multiply.
    typedef enum logic {
        RUN      = 1'b0,
        MUL_BUSY = 1'b1
    } ctrlState_t;

    // Pipeline control strobes produced each cycle.
    typedef struct packed {
        logic pcWe;
        logic ifidWe;
        logic ifidFlush;
        logic idexWe;
        logic idexFlush;
        logic exmemBubble;
        logic mulDone;
    } ctrlOut_t;

    // Everything flowing normally.
    localparam ctrlOut_t CTRL_RUN = '{
        pcWe: 1'b1, ifidWe: 1'b1, ifidFlush: 1'b0, idexWe: 1'b1,
        idexFlush: 1'b0, exmemBubble: 1'b0, mulDone: 1'b0};

    // Held in reset: nothing advances, every stage is emptied.
    localparam ctrlOut_t CTRL_RESET = '{
        pcWe: 1'b0, ifidWe: 1'b0, ifidFlush: 1'b1, idexWe: 1'b0,
        idexFlush: 1'b1, exmemBubble: 1'b1, mulDone: 1'b0};

    // Taken branch in EX: fetch the target, squash the two younger instructions.
    localparam ctrlOut_t CTRL_BRANCH = '{
        pcWe: 1'b1, ifidWe: 1'b1, ifidFlush: 1'b1, idexWe: 1'b1,
        idexFlush: 1'b1, exmemBubble: 1'b0, mulDone: 1'b0};

    // Load-use: hold PC and IF/ID, let one bubble into EX.
    localparam ctrlOut_t CTRL_LOAD_USE = '{
        pcWe: 1'b0, ifidWe: 1'b0, ifidFlush: 1'b0, idexWe: 1'b1,
        idexFlush: 1'b1, exmemBubble: 1'b0, mulDone: 1'b0};

    // Multiply still computing: freeze front end, feed EX/MEM bubbles.
    localparam ctrlOut_t CTRL_MUL_STALL = '{
        pcWe: 1'b0, ifidWe: 1'b0, ifidFlush: 1'b0, idexWe: 1'b0,
        idexFlush: 1'b0, exmemBubble: 1'b1, mulDone: 1'b0};

    // Final multiply cycle: result goes to EX/MEM, front end resumes.
    localparam ctrlOut_t CTRL_MUL_DONE = '{
        pcWe: 1'b1, ifidWe: 1'b1, ifidFlush: 1'b0, idexWe: 1'b1,
        idexFlush: 1'b0, exmemBubble: 1'b0, mulDone: 1'b1};

    // True when a written register (non-zero) matches a read register.
    function automatic logic regMatch(input logic [4:0] wn, input logic [4:0] rn);
        return (wn != 5'd0) && (wn == rn);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard comparator: the instruction in ID reads a register that
// the load currently in EX has not yet produced.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic       ex_mem_read,
    input  logic [4:0] ex_wn,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    output logic       load_use
);

    // Register 0 is never a real dependency; rt only counts if ID reads it.
    always_comb begin
        load_use = ex_mem_read &&
                   (regMatch(ex_wn, id_rs) || (id_uses_rt && regMatch(ex_wn, id_rt)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use stalls,
// taken-branch flushes, multi-cycle multiply freeze, and statistics counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int STAT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic              id_uses_rt,
    input  logic              ex_mem_read,
    input  logic [4:0]        ex_wn,
    input  logic              ex_branch_taken,
    input  logic              ex_mul_start,
    input  logic              stat_clr,
    output logic              pc_we,
    output logic              ifid_we,
    output logic              ifid_flush,
    output logic              idex_we,
    output logic              idex_flush,
    output logic              exmem_bubble,
    output logic              mul_done,
    output logic              busy,
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] flush_cnt
);

    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    // Busy cycles left after the start cycle before the done cycle.
    localparam logic [CNT_W-1:0] MUL_LOAD = (MUL_LAT > 1) ? CNT_W'(MUL_LAT - 2) : '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

    ctrlState_t       state, nextState;
    logic [CNT_W-1:0] busyCnt, busyCntNext;
    ctrlOut_t         ctrl;
    logic             flushEvent;
    logic             loadUse;

    hazard_detect uHazard (
        .ex_mem_read (ex_mem_read),
        .ex_wn       (ex_wn),
        .id_rs       (id_rs),
        .id_rt       (id_rt),
        .id_uses_rt  (id_uses_rt),
        .load_use    (loadUse)
    );

    // FSM state and multiply countdown registers.
    always_ff @(posedge clk) begin
        state   <= nextState;
        busyCnt <= busyCntNext;
    end

    // Next state and control strobes; reset overrides everything.
    always_comb begin
        ctrl        = CTRL_RUN;
        nextState   = state;
        busyCntNext = busyCnt;
        flushEvent  = 1'b0;
        if (rst) begin
            ctrl        = CTRL_RESET;
            nextState   = RUN;
            busyCntNext = '0;
        end else begin
            unique case (state)
                RUN: begin
                    if (ex_branch_taken) begin
                        ctrl       = CTRL_BRANCH;
                        flushEvent = 1'b1;
                    end else if (ex_mul_start) begin
                        if (MUL_LAT > 1) begin
                            ctrl        = CTRL_MUL_STALL;
                            busyCntNext = MUL_LOAD;
                            nextState   = MUL_BUSY;
                        end else begin
                            ctrl = CTRL_MUL_DONE;
                        end
                    end else if (loadUse) begin
                        ctrl = CTRL_LOAD_USE;
                    end
                end
                MUL_BUSY: begin
                    if (busyCnt != '0) begin
                        ctrl        = CTRL_MUL_STALL;
                        busyCntNext = busyCnt - CNT_ONE;
                    end else begin
                        ctrl      = CTRL_MUL_DONE;
                        nextState = RUN;
                    end
                end
                default: nextState = RUN;
            endcase
        end
    end

    // Saturating statistics; a clear request beats a same-cycle increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!ctrl.pcWe && (stall_cnt != '1)) stall_cnt <= stall_cnt + STAT_ONE;
            if (flushEvent && (flush_cnt != '1)) flush_cnt <= flush_cnt + STAT_ONE;
        end
    end

    // Drive the individual strobes from the selected control bundle.
    always_comb begin
        pc_we        = ctrl.pcWe;
        ifid_we      = ctrl.ifidWe;
        ifid_flush   = ctrl.ifidFlush;
        idex_we      = ctrl.idexWe;
        idex_flush   = ctrl.idexFlush;
        exmem_bubble = ctrl.exmemBubble;
        mul_done     = ctrl.mulDone;
        busy         = (state == MUL_BUSY) && !rst;
    end

    // A branch and a multiply cannot both occupy EX; the branch is honoured.
    illegalBranchMul: assert property (@(posedge clk) disable iff (rst)
        (state == RUN) |-> !(ex_branch_taken && ex_mul_start));

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table,
// randomized run against a reference model, and a MUL_LAT=1 / narrow-counter
// instance for the single-cycle multiply and saturation corners.
module tb_pipeline_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int STAT_W  = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance signals
    logic        rst, statClr, br, mul, mr, ur;
    logic [4:0]  wn, rs, rt;
    logic        pcWe, ifidWe, ifidFlush, idexWe, idexFlush, exmemBubble, mulDone, busy;
    logic [STAT_W-1:0] stallCnt, flushCnt;

    // Second instance: single-cycle multiply, 4-bit statistics
    logic        bRst, bClr, bMul, bMr;
    logic [4:0]  bWn, bRs;
    logic        bPcWe, bIfidWe, bIfidFlush, bIdexWe, bIdexFlush, bBubble, bMulDone, bBusy;
    logic [3:0]  bStall, bFlush;

    pipeline_hazard_ctrl #(.MUL_LAT(MUL_LAT), .STAT_W(STAT_W)) dut (
        .clk(clk), .rst(rst), .id_rs(rs), .id_rt(rt), .id_uses_rt(ur),
        .ex_mem_read(mr), .ex_wn(wn), .ex_branch_taken(br), .ex_mul_start(mul),
        .stat_clr(statClr), .pc_we(pcWe), .ifid_we(ifidWe), .ifid_flush(ifidFlush),
        .idex_we(idexWe), .idex_flush(idexFlush), .exmem_bubble(exmemBubble),
        .mul_done(mulDone), .busy(busy), .stall_cnt(stallCnt), .flush_cnt(flushCnt)
    );

    pipeline_hazard_ctrl #(.MUL_LAT(1), .STAT_W(4)) dutB (
        .clk(clk), .rst(bRst), .id_rs(bRs), .id_rt(5'd0), .id_uses_rt(1'b0),
        .ex_mem_read(bMr), .ex_wn(bWn), .ex_branch_taken(1'b0), .ex_mul_start(bMul),
        .stat_clr(bClr), .pc_we(bPcWe), .ifid_we(bIfidWe), .ifid_flush(bIfidFlush),
        .idex_we(bIdexWe), .idex_flush(bIdexFlush), .exmem_bubble(bBubble),
        .mul_done(bMulDone), .busy(bBusy), .stall_cnt(bStall), .flush_cnt(bFlush)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Output order: pc_we ifid_we ifid_flush idex_we idex_flush exmem_bubble mul_done busy
    function automatic logic [7:0] aOut();
        return {pcWe, ifidWe, ifidFlush, idexWe, idexFlush, exmemBubble, mulDone, busy};
    endfunction

    function automatic logic [7:0] bOut();
        return {bPcWe, bIfidWe, bIfidFlush, bIdexWe, bIdexFlush, bBubble, bMulDone, bBusy};
    endfunction

    localparam logic [7:0] O_RST  = 8'b0010_1100;
    localparam logic [7:0] O_RUN  = 8'b1101_0000;
    localparam logic [7:0] O_LU   = 8'b0001_1000;
    localparam logic [7:0] O_BR   = 8'b1111_1000;
    localparam logic [7:0] O_MST  = 8'b0000_0100;
    localparam logic [7:0] O_BSY  = 8'b0000_0101;
    localparam logic [7:0] O_DONE = 8'b1101_0011;
    localparam logic [7:0] O_MD1  = 8'b1101_0010;

    typedef struct {
        logic       rst, clr, br, mul, mr;
        logic [4:0] wn, rs, rt;
        logic       ur;
        logic [7:0] out;
        int         stall, flush;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, c, b, m, lm, input logic [4:0] w, s, t,
                                input logic u, input logic [7:0] o, input int sc, fc);
        vec_t v;
        v.rst = r; v.clr = c; v.br = b; v.mul = m; v.mr = lm;
        v.wn = w; v.rs = s; v.rt = t; v.ur = u; v.out = o; v.stall = sc; v.flush = fc;
        return v;
    endfunction

    task automatic driveA(input logic r, c, b, m, lm, input logic [4:0] w, s, t, input logic u);
        rst = r; statClr = c; br = b; mul = m; mr = lm; wn = w; rs = s; rt = t; ur = u;
    endtask

    // Reference model: cycles of EX still owed to an in-flight multiply, plus counters.
    int mulLeft = 0;
    int mStall  = 0;
    int mFlush  = 0;
    localparam int STAT_MAX = (1 << STAT_W) - 1;

    function automatic logic [7:0] modelOut(input logic r, b, m, lm, input logic [4:0] w, s, t,
                                            input logic u);
        if (r) return O_RST;
        if (mulLeft > 1) return O_BSY;
        if (mulLeft == 1) return O_DONE;
        if (b) return O_BR;
        if (m) return (MUL_LAT == 1) ? O_MD1 : O_MST;
        if (lm && w != 0 && (w == s || (u && w == t))) return O_LU;
        return O_RUN;
    endfunction

    task automatic modelStep(input logic r, c, b, m, input logic [7:0] o);
        if (r) begin
            mulLeft = 0; mStall = 0; mFlush = 0;
        end else begin
            if (c) begin
                mStall = 0; mFlush = 0;
            end else begin
                if (!o[7] && mStall < STAT_MAX) mStall++;
                if (mulLeft == 0 && b && mFlush < STAT_MAX) mFlush++;
            end
            if (mulLeft > 0) mulLeft--;
            else if (!b && m && MUL_LAT > 1) mulLeft = MUL_LAT - 1;
        end
    endtask

    initial begin
        driveA(1, 0, 0, 0, 0, 0, 0, 0, 0);
        bRst = 1'b1; bClr = 1'b0; bMul = 1'b0; bMr = 1'b0; bWn = '0; bRs = '0;
        repeat (2) @(posedge clk);
        #1;

        //           rst clr br mul mr wn rs rt ur  out     stall flush
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 2, 0, 0, O_LU,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, O_RUN,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 3, 0, O_RUN,  1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 3, 1, 3, 1, O_LU,   1, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 2, 2, 0, 0, O_BR,   2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  2, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, O_MST,  2, 1));
        tbl.push_back(mk(0, 0, 1, 0, 1, 2, 2, 0, 0, O_BSY,  3, 1));
        tbl.push_back(mk(0, 0, 0, 1, 1, 2, 2, 0, 0, O_BSY,  4, 1));
        tbl.push_back(mk(0, 0, 0, 0, 1, 2, 2, 0, 0, O_DONE, 5, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  5, 1));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, O_MST,  5, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_BSY,  6, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, O_RST,  7, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, O_BR,   0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 7, 7, 0, 0, O_LU,   0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 9, 4, 9, 1, O_LU,   0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, O_RUN,  1, 0));

        foreach (tbl[i]) begin
            driveA(tbl[i].rst, tbl[i].clr, tbl[i].br, tbl[i].mul, tbl[i].mr,
                   tbl[i].wn, tbl[i].rs, tbl[i].rt, tbl[i].ur);
            @(negedge clk);
            check($sformatf("vec%0d_out", i), 32'(aOut()), 32'(tbl[i].out));
            check($sformatf("vec%0d_stall", i), 32'(stallCnt), tbl[i].stall);
            check($sformatf("vec%0d_flush", i), 32'(flushCnt), tbl[i].flush);
            @(posedge clk);
            #1;
        end

        // Randomized run against the model, starting from a clean reset.
        driveA(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        mulLeft = 0; mStall = 0; mFlush = 0;
        for (int n = 0; n < 3000; n++) begin
            logic r, c, b, m, lm, u;
            logic [4:0] w, s, t;
            logic [7:0] e;
            r  = ($urandom_range(0, 99) == 0);
            c  = ($urandom_range(0, 39) == 0);
            b  = ($urandom_range(0, 7) == 0);
            m  = !b && ($urandom_range(0, 9) == 0);
            lm = $urandom_range(0, 1) == 1;
            u  = $urandom_range(0, 1) == 1;
            w  = 5'($urandom_range(0, 3));
            s  = 5'($urandom_range(0, 3));
            t  = 5'($urandom_range(0, 3));
            driveA(r, c, b, m, lm, w, s, t, u);
            e = modelOut(r, b, m, lm, w, s, t, u);
            @(negedge clk);
            check($sformatf("rand%0d_out", n), 32'(aOut()), 32'(e));
            check($sformatf("rand%0d_stall", n), 32'(stallCnt), mStall);
            check($sformatf("rand%0d_flush", n), 32'(flushCnt), mFlush);
            @(posedge clk);
            #1;
            modelStep(r, c, b, m, e);
        end
        driveA(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Single-cycle multiply: done in the start cycle, no stall, never busy.
        @(posedge clk);
        #1;
        bRst = 1'b0;
        bMul = 1'b1;
        @(negedge clk);
        check("b_mul1_done", 32'(bOut()), 32'(O_MD1));
        @(posedge clk);
        #1;
        bMul = 1'b0;
        @(negedge clk);
        check("b_after_mul", 32'(bOut()), 32'(O_RUN));
        check("b_stall_zero", 32'(bStall), 0);

        // Continuous load-use stalls drive the 4-bit counter into saturation.
        @(posedge clk);
        #1;
        bMr = 1'b1; bWn = 5'd5; bRs = 5'd5;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            check($sformatf("b_sat%0d", i), 32'(bStall), (i > 15) ? 15 : i);
            @(posedge clk);
            #1;
        end
        bClr = 1'b1;
        @(negedge clk);
        check("b_pre_clr", 32'(bStall), 15);
        @(posedge clk);
        #1;
        bClr = 1'b0; bMr = 1'b0;
        @(negedge clk);
        check("b_clr", 32'(bStall), 0);
        check("b_flush", 32'(bFlush), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
